// File: rtl/machine_seq_if.sv
// Control bundle between the enable controller/IR and the instruction-cycle sequencer.
// Carries the enable, opcode and zero flag in, and the PC/IR/ACC/memory/bus strobes and debug counter out.
// master = the controlling side (enable controller/datapath), slave = machine_seq.
interface machine_seq_if #(
  parameter int CNT_W = 16
);
  logic             ena;          // sequencer enable
  logic [2:0]       opcode;       // IR opcode field, valid from S2 onward
  logic             zero;         // accumulator == 0
  logic             inc_pc;       // increment PC
  logic             load_pc;      // load PC from IR address field
  logic             load_acc;     // load accumulator from ALU
  logic             load_ir;      // load one IR byte from data bus
  logic             rd;           // memory read strobe
  logic             wr;           // memory write strobe
  logic             datactl_ena;  // drive accumulator onto data bus
  logic             halt;         // CPU halted
  logic [CNT_W-1:0] retired;      // completed-instruction count

  modport master (
    output ena, opcode, zero,
    input  inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, retired
  );

  modport slave (
    input  ena, opcode, zero,
    output inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, retired
  );
endinterface

// File: rtl/machine_seq.sv
// Instruction-cycle sequencer: steps S0..S7 per instruction and decodes opcode/zero into control strobes.
// Latency: strobes are combinational from the state register; one instruction takes exactly 8 cycles.
// Backpressure: none; ena=0 aborts to S0 (SHALT is held) and forces all strobes except halt low.
// Ports: clk, rst (sync, active-high); bus (machine_seq_if.slave): ena/opcode/zero in,
//        inc_pc/load_pc/load_acc/load_ir/rd/wr/datactl_ena/halt strobes and retired counter out.
module machine_seq #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  machine_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    S0    = 4'd0,
    S1    = 4'd1,
    S2    = 4'd2,
    S3    = 4'd3,
    S4    = 4'd4,
    S5    = 4'd5,
    S6    = 4'd6,
    S7    = 4'd7,
    SHALT = 4'd8
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic w_alu;
  logic w_hlt;
  logic w_skz;
  logic w_sto;
  logic w_jmp;

  assign w_alu = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                 (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign w_hlt = (bus.opcode == OP_HLT);
  assign w_skz = (bus.opcode == OP_SKZ);
  assign w_sto = (bus.opcode == OP_STO);
  assign w_jmp = (bus.opcode == OP_JMP);

  // State register and retired counter. Only a full S7->S0 step with ena
  // counts; an aborted instruction or HLT never reaches that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S7) && bus.ena) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next state. SHALT is sticky irrespective of ena; anything else falls
  // back to S0 whenever ena drops.
  always_comb begin
    w_next = r_state;
    if (r_state == SHALT) begin
      w_next = SHALT;
    end else if (!bus.ena) begin
      w_next = S0;
    end else begin
      case (r_state)
        S0:      w_next = S1;
        S1:      w_next = S2;
        S2:      w_next = S3;
        S3:      w_next = w_hlt ? SHALT : S4;
        S4:      w_next = S5;
        S5:      w_next = S6;
        S6:      w_next = S7;
        S7:      w_next = S0;
        default: w_next = S0;
      endcase
    end
  end

  // Strobe decode. halt in SHALT is not gated by ena so it stays up until
  // reset; every other strobe requires ena.
  always_comb begin
    bus.inc_pc      = 1'b0;
    bus.load_pc     = 1'b0;
    bus.load_acc    = 1'b0;
    bus.load_ir     = 1'b0;
    bus.rd          = 1'b0;
    bus.wr          = 1'b0;
    bus.datactl_ena = 1'b0;
    bus.halt        = 1'b0;
    if (r_state == SHALT) begin
      bus.halt = 1'b1;
    end else if (bus.ena) begin
      case (r_state)
        S0: begin
          bus.rd      = 1'b1;
          bus.load_ir = 1'b1;
        end
        S1: begin
          bus.rd      = 1'b1;
          bus.load_ir = 1'b1;
          bus.inc_pc  = 1'b1;
        end
        S3: begin
          if (w_hlt) bus.halt   = 1'b1;
          else       bus.inc_pc = 1'b1;
        end
        S4: begin
          bus.load_pc     = w_jmp;
          bus.datactl_ena = w_sto;
          bus.rd          = w_alu;
        end
        S5: begin
          bus.rd          = w_alu;
          bus.load_acc    = w_alu;
          bus.load_pc     = w_jmp;
          bus.wr          = w_sto;
          bus.datactl_ena = w_sto;
          bus.inc_pc      = w_skz && bus.zero;
        end
        S6: begin
          bus.rd          = w_alu;
          bus.datactl_ena = w_sto;
        end
        S7: begin
          // Second increment of SKZ; together with S5 it skips a 2-byte instruction.
          bus.inc_pc = w_skz && bus.zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.retired = r_retired;

endmodule

// File: tb/tb_machine_seq.sv
module tb_machine_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  machine_seq_if #(.CNT_W(16)) bus  ();
  machine_seq_if #(.CNT_W(3))  bus3 ();

  // Narrow-counter instance shares the stimulus so counter wrap is reached quickly.
  assign bus3.ena    = bus.ena;
  assign bus3.opcode = bus.opcode;
  assign bus3.zero   = bus.zero;

  machine_seq #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  machine_seq #(.CNT_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  // Strobe bit order: {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}
  logic [7:0] q_exp [$];
  int         q_ret [$];
  string      q_tag [$];

  int total = 0;
  int bad   = 0;
  int n_ret = 0;

  // Monitor: one expected entry per stimulated cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [7:0] e;
      logic [7:0] obs;
      int         r;
      string      t;
      e = q_exp.pop_front();
      r = q_ret.pop_front();
      t = q_tag.pop_front();
      obs = {bus.inc_pc, bus.load_pc, bus.load_acc, bus.load_ir,
             bus.rd, bus.wr, bus.datactl_ena, bus.halt};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s strobes got=%b want=%b", t, obs, e);
      end
      total++;
      if (bus.retired !== 16'(r)) begin
        bad++;
        $display("FAIL %s retired got=%h want=%h", t, bus.retired, 16'(r));
      end
      total++;
      if (bus3.retired !== 3'(r)) begin
        bad++;
        $display("FAIL %s retired3 got=%0d want=%0d", t, bus3.retired, 3'(r));
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic z, input logic [7:0] exp, input string tag);
    @(posedge clk);
    #1;
    rst        = r;
    bus.ena    = e;
    bus.opcode = op;
    bus.zero   = z;
    q_exp.push_back(exp);
    q_ret.push_back(n_ret);
    q_tag.push_back(tag);
  endtask

  // Masks: bit k = strobe expected in state Sk. load_ir is always S0,S1.
  task automatic do_instr(input logic [2:0] op, input logic z,
                          input logic [7:0] m_inc, input logic [7:0] m_lpc,
                          input logic [7:0] m_lacc, input logic [7:0] m_rd,
                          input logic [7:0] m_wr, input logic [7:0] m_dctl,
                          input string tag);
    logic [7:0] m_ir;
    m_ir = 8'h03;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, op, z,
           {m_inc[k], m_lpc[k], m_lacc[k], m_ir[k], m_rd[k], m_wr[k], m_dctl[k], 1'b0},
           $sformatf("%s_S%0d", tag, k));
    end
    n_ret++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.ena    = 1'b0;
    bus.opcode = 3'b000;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);

    step(1'b0, 1'b0, 3'b000, 1'b0, 8'h00, "reset_idle0");
    step(1'b0, 1'b0, 3'b000, 1'b0, 8'h00, "reset_idle1");

    //        op      z     inc    lpc    lacc   rd     wr     dctl
    do_instr(3'b010, 1'b0, 8'h0A, 8'h00, 8'h20, 8'h73, 8'h00, 8'h00, "add");
    do_instr(3'b011, 1'b1, 8'h0A, 8'h00, 8'h20, 8'h73, 8'h00, 8'h00, "and");
    do_instr(3'b100, 1'b0, 8'h0A, 8'h00, 8'h20, 8'h73, 8'h00, 8'h00, "xor");
    do_instr(3'b101, 1'b1, 8'h0A, 8'h00, 8'h20, 8'h73, 8'h00, 8'h00, "lda");
    do_instr(3'b110, 1'b1, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h20, 8'h70, "sto");
    do_instr(3'b001, 1'b1, 8'hAA, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, "skz_z1");
    do_instr(3'b001, 1'b0, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, "skz_z0");
    do_instr(3'b111, 1'b0, 8'h0A, 8'h30, 8'h00, 8'h03, 8'h00, 8'h00, "jmp");

    // JMP aborted in S5: strobes drop, sequencer restarts at S0, no count.
    step(1'b0, 1'b1, 3'b111, 1'b0, 8'h18, "jab_S0");
    step(1'b0, 1'b1, 3'b111, 1'b0, 8'h98, "jab_S1");
    step(1'b0, 1'b1, 3'b111, 1'b0, 8'h00, "jab_S2");
    step(1'b0, 1'b1, 3'b111, 1'b0, 8'h80, "jab_S3");
    step(1'b0, 1'b1, 3'b111, 1'b0, 8'h40, "jab_S4");
    step(1'b0, 1'b0, 3'b111, 1'b0, 8'h00, "jab_S5_off");
    do_instr(3'b010, 1'b0, 8'h0A, 8'h00, 8'h20, 8'h73, 8'h00, 8'h00, "add_after_abort");

    // HLT: halt from S3 onward, held with no other strobes.
    step(1'b0, 1'b1, 3'b000, 1'b0, 8'h18, "hlt_S0");
    step(1'b0, 1'b1, 3'b000, 1'b0, 8'h98, "hlt_S1");
    step(1'b0, 1'b1, 3'b000, 1'b0, 8'h00, "hlt_S2");
    step(1'b0, 1'b1, 3'b000, 1'b0, 8'h01, "hlt_S3");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 3'b010, 1'b1, 8'h01, $sformatf("hlt_hold%0d", i));
    end
    step(1'b1, 1'b1, 3'b000, 1'b0, 8'h01, "hlt_in_rst");
    n_ret = 0;
    step(1'b0, 1'b0, 3'b000, 1'b0, 8'h00, "post_rst");
    do_instr(3'b110, 1'b0, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h20, 8'h70, "sto_after_rst");
    step(1'b0, 1'b0, 3'b000, 1'b0, 8'h00, "final_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_seq.md
# machine_seq

Instruction-cycle sequencer of the RISC CPU. It sits directly downstream of the fetch/enable controller and consumes its `ena` output. Once enabled, it steps through a fixed 8-state cycle per instruction. In each state it decodes the current opcode and the accumulator zero flag into the control strobes for the PC, IR, accumulator, memory and data bus. It also keeps a retired-instruction counter for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `ena`, input, 1: sequencer enable from the enable controller.
- `opcode`, input, 3: IR opcode field. Valid from state S2 onward.
- `zero`, input, 1: accumulator-equals-zero flag.
- `inc_pc`, output, 1: increment PC.
- `load_pc`, output, 1: load PC from the IR address field.
- `load_acc`, output, 1: load the accumulator from the ALU.
- `load_ir`, output, 1: load one IR byte from the data bus.
- `rd`, output, 1: memory read strobe.
- `wr`, output, 1: memory write strobe.
- `datactl_ena`, output, 1: drive the accumulator onto the data bus.
- `halt`, output, 1: CPU halted.
- `retired`, output, CNT_W: count of completed instructions.

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALU group = ADD, AND, XOR, LDA.
- States: S0..S7 and SHALT. The state is a register; strobes decode combinationally from state, `opcode` and `zero`.
- While `ena`=0, all strobes are 0.
- Per-state strobes; anything not listed is 0:
  - S0: `rd`, `load_ir` (high IR byte).
  - S1: `rd`, `load_ir`, `inc_pc` (low IR byte).
  - S2: none.
  - S3: HLT → `halt`; any other opcode → `inc_pc`.
  - S4: JMP → `load_pc`; STO → `datactl_ena`; ALU group → `rd`; SKZ → none.
  - S5: ALU group → `rd`, `load_acc`; JMP → `load_pc`; STO → `wr`, `datactl_ena`; SKZ with `zero`=1 → `inc_pc`.
  - S6: ALU group → `rd`; STO → `datactl_ena`.
  - S7: SKZ with `zero`=1 → `inc_pc`. Across S5 and S7 this gives two increments, skipping one 2-byte instruction.
  - SHALT: `halt`=1; all other strobes 0.
- Transitions, taken only when `ena`=1:
  - Sk → Sk+1 for k=0..6.
  - S7 → S0.
  - S3 with opcode HLT → SHALT.
  - SHALT → SHALT until `rst`.
- When `ena`=0: the next state is S0, regardless of the current state. SHALT is the exception and is held.
- `retired` increments by 1 on every S7→S0 transition. It wraps from 2^CNT_W−1 to 0. It does not count HLT.
- `rd` and `wr` are mutually exclusive in every state. `load_pc` and `inc_pc` are never both asserted.

## Timing
- Reset (`rst`=1 at a rising edge): state=S0 and `retired`=0 on the next cycle. All strobes read 0 while `ena`=0, which the upstream controller guarantees after reset.
- `rst` overrides `ena` and all state, including SHALT and mid-instruction states.
- First instruction: S0 is the first cycle with `ena`=1. The sequencer occupies S0 during that cycle, so `rd` and `load_ir` are already asserted.
- Instruction latency: exactly 8 cycles, S0 to S7. Back-to-back instructions follow with no gap.
- HLT: `halt` rises in S3 and stays at 1 from S3 onward. It remains 1 until `rst`.
- `zero` is sampled combinationally in S5 and S7 of SKZ. Its value in each of those cycles decides that cycle's `inc_pc`.
- If `ena` falls mid-instruction, the sequencer returns to S0 on the next edge and the partial instruction is not counted.

## Test plan
- Reset, then `ena`=1 with `opcode`=010 (ADD), run 8 cycles → `rd` high in S0, S1, S4, S5, S6; `inc_pc` in S1 and S3; `load_acc` only in S5; `retired`=1 after S7.
- `opcode`=110 (STO) → `datactl_ena` high in S4–S6; `wr` high only in S5; `rd` low in S4–S7.
- `opcode`=001 (SKZ): with `zero`=1 → `inc_pc` in S1, S3, S5, S7 (4 pulses); with `zero`=0 → 2 pulses.
- `opcode`=000 (HLT) → `halt` from S3 onward; state held for 20 further cycles with no other strobes and `retired` unchanged. Then `rst` → state S0 and `retired`=0.
- `opcode`=111 (JMP) → `load_pc` in S4 and S5; `inc_pc` only in S1 and S3. Drop `ena` in S5 → next state S0, `retired` not incremented.
- Preload `retired` to 0xFFFF by running 65535 instructions (or force the counter in the bench), then complete one instruction → `retired`=0x0000.
